// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_pkg;

  // Sequencer states: normal flow, or frozen while the MDU grinds.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  localparam int REG_AW_DEF  = 5;
  localparam int MDU_LAT_DEF = 32;

  // Register $0 is hardwired to zero and never carries a dependency.
  localparam logic [4:0] ZERO_REG = 5'd0;

  // Bundle of all control outputs, ordered MSB first as listed.
  typedef struct packed {
    logic enF;
    logic enD;
    logic enE;
    logic enM;
    logic flushD;
    logic flushE;
    logic flushM;
    logic mdu_busy;
  } ctrl_t;

  localparam ctrl_t CTRL_DEF   = '{enF:1'b1, enD:1'b1, enE:1'b1, enM:1'b1,
                                   flushD:1'b0, flushE:1'b0, flushM:1'b0, mdu_busy:1'b0};
  localparam ctrl_t CTRL_FLUSH = '{enF:1'b1, enD:1'b1, enE:1'b1, enM:1'b1,
                                   flushD:1'b1, flushE:1'b1, flushM:1'b1, mdu_busy:1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-info / pipeline-control bundle between datapath and sequencer.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rsD;
  logic [REG_AW-1:0] rtD;
  logic [REG_AW-1:0] rtE;
  logic              memreadE;
  logic              regwriteE;
  logic [REG_AW-1:0] writeregE;
  logic              branchD;
  logic              branch_takenD;
  logic              mdu_startE;
  logic              exc;
  logic              enF;
  logic              enD;
  logic              enE;
  logic              enM;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic              mdu_busy;

  // Datapath side: reports stage contents, consumes enables/flushes.
  modport master (
    output rsD, rtD, rtE, memreadE, regwriteE, writeregE,
           branchD, branch_takenD, mdu_startE, exc,
    input  enF, enD, enE, enM, flushD, flushE, flushM, mdu_busy
  );

  // Sequencer side.
  modport slave (
    input  rsD, rtD, rtE, memreadE, regwriteE, writeregE,
           branchD, branch_takenD, mdu_startE, exc,
    output enF, enD, enE, enM, flushD, flushE, flushM, mdu_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Register-specifier comparators for load-use and branch-operand hazards.
module hazard_cmp
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rtE,
  input  logic              memreadE,
  input  logic              regwriteE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              branchD,
  output logic              lu_haz,
  output logic              br_haz
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  // Load in E whose target feeds D: data not ready until after M.
  assign lu_haz = memreadE && (rtE != ZR) && ((rtE == rsD) || (rtE == rtD));

  // Branch compares in D, so any in-flight write from E is too late to forward.
  assign br_haz = branchD && regwriteE && (writeregE != ZR) &&
                  ((writeregE == rsD) || (writeregE == rtD));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage F/D/E/M/W pipeline.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [0:0] ST_WAIT = MDU_WAIT;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  logic [0:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             lu_haz, br_haz;
  ctrl_t            ctrl;

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
    .rsD       (bus.rsD),
    .rtD       (bus.rtD),
    .rtE       (bus.rtE),
    .memreadE  (bus.memreadE),
    .regwriteE (bus.regwriteE),
    .writeregE (bus.writeregE),
    .branchD   (bus.branchD),
    .lu_haz    (lu_haz),
    .br_haz    (br_haz)
  );

  // Next state/counter: exception aborts everything, else MDU entry/countdown.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (bus.exc) begin
      state_nx = ST_RUN;
      cnt_nx   = '0;
    end else if (state == ST_WAIT) begin
      if (cnt == '0) state_nx = ST_RUN;
      else           cnt_nx   = cnt - 1'b1;
    end else if (bus.mdu_startE) begin
      state_nx = ST_WAIT;
      cnt_nx   = CNT_LOAD;
    end
  end

  // State and counter registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Output priority mux: reset > exc > MDU wait > stall > taken branch > default.
  always_comb begin
    ctrl = CTRL_DEF;
    if (!rst_n) begin
      ctrl = CTRL_FLUSH;
    end else if (bus.exc) begin
      ctrl = CTRL_FLUSH;
    end else if (state == ST_WAIT) begin
      ctrl.enF      = 1'b0;
      ctrl.enD      = 1'b0;
      ctrl.enE      = 1'b0;
      ctrl.flushM   = 1'b1;
      ctrl.mdu_busy = 1'b1;
    end else if (lu_haz || br_haz) begin
      // Hold F and D, inject one bubble into E per stalled cycle.
      ctrl.enF    = 1'b0;
      ctrl.enD    = 1'b0;
      ctrl.flushE = 1'b1;
    end else if (bus.branch_takenD) begin
      ctrl.flushD = 1'b1;
    end
  end

  assign bus.enF      = ctrl.enF;
  assign bus.enD      = ctrl.enD;
  assign bus.enE      = ctrl.enE;
  assign bus.enM      = ctrl.enM;
  assign bus.flushD   = ctrl.flushD;
  assign bus.flushE   = ctrl.flushE;
  assign bus.flushM   = ctrl.flushM;
  assign bus.mdu_busy = ctrl.mdu_busy;

endmodule
